// File: rtl/sum_latch_uart_top_if.sv
// Pad-frame bundle for SumLatchUART: enable, 8 inputs, 8 outputs, 8 bidirs.
// master = pad/board side driving the inputs, slave = the chip core.
interface sum_latch_uart_top_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena,
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ena,
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );
endinterface

// File: rtl/sum_latch_uart_top.sv
// SumLatchUART chip top: adds two 4-bit operands on a synchronized strobe,
// shows the latched 5-bit sum on uo_out and sends it as one UART byte.
// Optional feature macro: UART_PARITY_EN (even parity bit, 8E1 frame).
module sum_latch_uart_top #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sum_latch_uart_top_if.slave  pads
);

   localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned SUM_W  = 5;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   tx_state_t          state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [2:0]         bit_idx;
   logic [DATA_W-1:0]  shreg;
   logic               par_bit;
   logic               tx;
   logic               tx_busy;
   logic               sum_valid;
   logic [SUM_W-1:0]   sum_q;
   logic               sync1;
   logic               sync2;
   logic               sync3;

   logic               edge_c;
   logic               accept_c;
   logic               bit_end_c;
   logic [SUM_W-1:0]   sum_c;
   logic               unused_pins;

   // Rising edge of the synchronized strobe; accepted only while enabled and idle.
   assign edge_c    = sync2 & ~sync3;
   assign accept_c  = edge_c & pads.ena & ~tx_busy;
   assign bit_end_c = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign sum_c     = SUM_W'({1'b0, pads.ui_in[3:0]}) + SUM_W'({1'b0, pads.ui_in[7:4]});

   // Pad outputs are straight wiring of registered state.
   assign pads.uo_out  = {sum_q, sum_valid, tx_busy, tx};
   assign pads.uio_out = 8'h00;
   assign pads.uio_oe  = 8'h00;
   assign unused_pins  = ^pads.uio_in[7:1];

   // Strobe synchronizer, edge-detect FF, operand latch and UART TX state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync3     <= 1'b0;
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         sum_valid <= 1'b0;
         sum_q     <= '0;
      end else begin
         sync1 <= pads.uio_in[0];
         sync2 <= sync1;
         sync3 <= sync2;

         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (accept_c) begin
                  sum_q     <= sum_c;
                  sum_valid <= 1'b1;
                  shreg     <= {3'b000, sum_c};
                  par_bit   <= ^sum_c;
                  tx_busy   <= 1'b1;
                  tx        <= 1'b0;
                  state     <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx    <= par_bit;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[DATA_W-1:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_PARITY: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  tx      <= 1'b1;
                  state   <= ST_STOP;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  tx_busy <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= ST_IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_latch_uart_top.sv
// Randomized self-checking bench for sum_latch_uart_top: a frame-level model
// predicts the latched sum and the serial bit sequence on the TX pin.
module tb_sum_latch_uart_top;

   localparam int unsigned CPB = 87;
`ifdef UART_PARITY_EN
   localparam int unsigned FRAME = 11;
`else
   localparam int unsigned FRAME = 10;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sum_latch_uart_top_if pads ();

   sum_latch_uart_top #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pads  (pads)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [4:0] exp_sum;
   logic       exp_valid;

   // Count a comparison and report a mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Idle pad image: latched sum, valid flag, not busy, line high.
   task automatic check_idle(input string tag);
      check(tag, 32'(pads.uo_out), 32'({exp_sum, exp_valid, 2'b01}));
   endtask

   // Bit k of a UART frame carrying byte d (start, 8 data LSB first, [parity], stop).
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (FRAME == 11 && k == 9) return ^d;
      return 1'b1;
   endfunction

   // Strobe operands a/b, then check latency, latched sum and the whole serial frame.
   // mode 1: extra strobe mid-frame (must be dropped); mode 2: ena drops mid-frame.
   task automatic run_frame(input logic [3:0] a, input logic [3:0] b, input int mode);
      int         lat;
      int         off;
      bit         seen;
      logic [7:0] d;
      pads.ui_in     = {b, a};
      pads.uio_in[0] = 1'b1;
      lat  = 0;
      seen = 0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         tick(1);
         if (pads.uo_out[1]) begin
            seen = 1;
            lat  = i;
         end
      end
      check("latch_latency", 32'(lat), 32'd3);
      if (!seen) return;
      pads.uio_in[0] = 1'b0;
      exp_sum   = 5'(a) + 5'(b);
      exp_valid = 1'b1;
      pads.ui_in = 8'($urandom);
      check("sum", 32'(pads.uo_out[7:3]), 32'(exp_sum));
      check("sum_valid", 32'(pads.uo_out[2]), 32'd1);
      d   = {3'b000, exp_sum};
      off = 0;
      for (int k = 0; k < int'(FRAME); k++) begin
         tick(k * int'(CPB) + int'(CPB / 2) - off);
         off = k * int'(CPB) + int'(CPB / 2);
         check($sformatf("tx_bit%0d", k), 32'(pads.uo_out[0]), 32'(frame_bit(d, k)));
         if (k == 2 && mode == 1) begin
            pads.ui_in     = 8'h11;
            pads.uio_in[0] = 1'b1;
            tick(4);
            off += 4;
            pads.uio_in[0] = 1'b0;
         end
         if (k == 2 && mode == 2) pads.ena = 1'b0;
      end
      tick(int'(FRAME * CPB) - 1 - off);
      check("busy_last_stop", 32'(pads.uo_out[1]), 32'd1);
      tick(1);
      check("busy_drop", 32'(pads.uo_out[1]), 32'd0);
      check("tx_idle", 32'(pads.uo_out[0]), 32'd1);
      if (mode == 2) pads.ena = 1'b1;
      tick(20);
      check_idle("after_frame");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      pads.ena    = 1'b1;
      pads.ui_in  = 8'h00;
      pads.uio_in = 8'h00;
      exp_sum     = '0;
      exp_valid   = 1'b0;

      // Reset hold
      rst_n = 1'b0;
      tick(3);
      check("rst_uo_out", 32'(pads.uo_out), 32'h01);
      check("rst_uio_oe", 32'(pads.uio_oe), 32'h00);
      check("rst_uio_out", 32'(pads.uio_out), 32'h00);
      rst_n = 1'b1;
      tick(2);
      check_idle("post_reset");

      // 3 + 5 = 8, then the 15 + 15 = 30 boundary with a dropped mid-frame strobe
      run_frame(4'h3, 4'h5, 0);
      run_frame(4'hF, 4'hF, 1);

      // Strobe while disabled must be ignored
      pads.ena       = 1'b0;
      pads.ui_in     = 8'h21;
      pads.uio_in[0] = 1'b1;
      tick(4);
      pads.uio_in[0] = 1'b0;
      tick(6);
      check_idle("ena_off");
      pads.ena = 1'b1;
      tick(2);

      // ena dropped mid-frame, then a few random operand pairs
      run_frame(4'($urandom), 4'($urandom), 2);
      for (int i = 0; i < 3; i++) begin
         run_frame(4'($urandom), 4'($urandom), 0);
      end

      // Reset asserted mid-frame aborts the frame at once
      pads.ui_in     = 8'h77;
      pads.uio_in[0] = 1'b1;
      tick(300);
      rst_n = 1'b0;
      #1;
      exp_sum   = '0;
      exp_valid = 1'b0;
      check("reset_mid_frame", 32'(pads.uo_out), 32'h01);
      pads.uio_in[0] = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check_idle("reset_release");
      run_frame(4'($urandom), 4'($urandom), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
